decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter LOAD_OPCODE, default 5'b10100: opcode whose result arrives late; triggers load-use stall.
REQ-002 Parameter NOP_OPCODE, default 5'b00000: opcode driven on control_out for bubbles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 instr_in  input  16  instruction from fetch: [15:11] opcode, [10:7] rd/rs1, [6:3] rs2, [6:0] immediate.
REQ-006 npc_in  input  16  next-PC accompanying instr_in.
REQ-007 instr_valid  input  1  instr_in/npc_in valid this cycle.
REQ-008 flush  input  1  taken-branch kill from execute.
REQ-009 wb_en, wb_index[4:0], wb_data[15:0]  input  1/5/16  register-file write port from writeback.
REQ-010 control_in, dest_index_in  output  5/5  opcode and destination index to Execute.
REQ-011 reg1_data, reg2_data  output  16/16  operands: R[rd/rs1], R[rs2].
REQ-012 npc, immediate  output  16/7  forwarded npc_in and instr_in[6:0].
REQ-013 valid_out  output  1  pipeline register holds a real instruction.
REQ-014 stall  output  1  fetch must hold its current instruction.

Function
REQ-015 Block SHALL contain a 16x16 register file; R0 reads 0; writes with wb_index==0 or wb_index[4]==1 ignored.
REQ-016 All Execute-facing outputs SHALL be registered; latency instr_in -> outputs exactly 1 cycle.
REQ-017 dest_index_in SHALL equal {1'b0, instr[10:7]}; control_in SHALL equal instr[15:11].
REQ-018 FSM states: RUN, STALL; stall SHALL equal (state==STALL).
REQ-019 Hazard SHALL be: valid_out && control_in==LOAD_OPCODE && dest_index_in!=0 && (instr_in[10:7] or instr_in[6:3] equals dest_index_in[3:0]).
REQ-020 RUN, instr_valid, no hazard: load pipeline register from instr_in, valid_out=1, remain RUN.
REQ-021 RUN, instr_valid, hazard: capture instr_in/npc_in into hold register, output bubble, go STALL.
REQ-022 RUN, !instr_valid: output bubble.
REQ-023 STALL: ignore instr_in; issue held instruction with fresh register reads, valid_out=1, go RUN.
REQ-024 Bubble SHALL be control_in=NOP_OPCODE, dest_index_in=0, reg1/reg2/npc/immediate=0, valid_out=0.
REQ-025 flush SHALL take priority over all but reset: next cycle bubble, hold register discarded, state RUN, same-cycle instr_in dropped.
REQ-026 Simultaneous wb write and read of same index: see REQ-030/031.

Reset
REQ-027 On rising edge with rst_n==0: state RUN, stall=0, all outputs equal the bubble (REQ-024).
REQ-028 Reset SHALL clear all 16 registers to 0 and the hold register; reset mid-STALL discards held instruction.
REQ-029 First instruction SHALL be accepted the first edge after rst_n returns high.

Configuration
REQ-030 With DECODE_BYPASS_EN defined: same-edge write to read index SHALL supply wb_data to reg1_data/reg2_data.
REQ-031 Without DECODE_BYPASS_EN: same-edge read SHALL return the old register value; new value visible next read.

Verification
REQ-032 Reset, then wb R2=10, R3=3; instr opcode 00001 rd=2 rs2=3 -> next cycle control_in=00001, dest_index_in=2, reg1_data=10, reg2_data=3, valid_out=1.
REQ-033 Load to R4 (opcode 10100) then instr reading R4 -> bubble cycle with valid_out=0, stall=1, then dependent instr issued, stall=0, following instr accepted.
REQ-034 flush asserted while in STALL -> next cycle bubble, state RUN, held instruction never appears at outputs.
REQ-035 wb_en R5=16'h1234 same cycle as instr reading R5 -> reg1_data=16'h1234 with DECODE_BYPASS_EN, prior value without.
REQ-036 wb_index=0 data 16'hFFFF then read R0 -> reg1_data=0; wb_index=5'd20 -> no register changes.
REQ-037 rst_n low mid-stream with valid instructions -> outputs bubble next cycle, all registers read 0 afterwards.

Source files
------------

// File: rtl/decode_stage_if.sv
// Decode-stage bundle: fetch-side instruction, writeback port and Execute-facing pipeline outputs.
// master drives fetch/writeback/flush; slave is the decode stage itself.
interface decode_stage_if;
  logic [15:0] instr_in;
  logic [15:0] npc_in;
  logic        instr_valid;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_index;
  logic [15:0] wb_data;
  logic [4:0]  control_in;
  logic [4:0]  dest_index_in;
  logic [15:0] reg1_data;
  logic [15:0] reg2_data;
  logic [15:0] npc;
  logic [6:0]  immediate;
  logic        valid_out;
  logic        stall;

  modport master (
    output instr_in, npc_in, instr_valid, flush, wb_en, wb_index, wb_data,
    input  control_in, dest_index_in, reg1_data, reg2_data, npc, immediate, valid_out, stall
  );

  modport slave (
    input  instr_in, npc_in, instr_valid, flush, wb_en, wb_index, wb_data,
    output control_in, dest_index_in, reg1_data, reg2_data, npc, immediate, valid_out, stall
  );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: 16x16 register file, load-use stall FSM and registered decode/execute pipeline register.
// Optional macro DECODE_BYPASS_EN forwards a same-edge writeback onto the operand reads.
module decode_stage #(
  parameter logic [4:0] LOAD_OPCODE = 5'b10100,
  parameter logic [4:0] NOP_OPCODE  = 5'b00000
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave dif
);

  // state | meaning
  // RUN   | accepting instructions from fetch
  // STALL | replaying the instruction held behind a load
  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [15:0] regs_q [16];
  logic [15:0] hold_instr_q, hold_npc_q;

  logic [4:0]  ctrl_q, dest_q;
  logic [15:0] reg1_q, reg2_q, npc_q;
  logic [6:0]  imm_q;
  logic        valid_q;

  logic [15:0] src_instr, src_npc, rd1, rd2;
  logic [3:0]  rs1, rs2;
  logic        wr_ok, hazard, issue, hold_load;

  always_comb begin
    src_instr = (state_q == STALL) ? hold_instr_q : dif.instr_in;
    src_npc   = (state_q == STALL) ? hold_npc_q : dif.npc_in;
    rs1       = src_instr[10:7];
    rs2       = src_instr[6:3];
    wr_ok     = dif.wb_en && !dif.wb_index[4] && (dif.wb_index[3:0] != 4'd0);
    rd1       = regs_q[rs1];
    rd2       = regs_q[rs2];
`ifdef DECODE_BYPASS_EN
    if (wr_ok && (dif.wb_index[3:0] == rs1)) rd1 = dif.wb_data;
    if (wr_ok && (dif.wb_index[3:0] == rs2)) rd2 = dif.wb_data;
`endif
    hazard = valid_q && (ctrl_q == LOAD_OPCODE) && (dest_q != 5'd0) &&
             ((dif.instr_in[10:7] == dest_q[3:0]) || (dif.instr_in[6:3] == dest_q[3:0]));

    state_d   = state_q;
    issue     = 1'b0;
    hold_load = 1'b0;
    if (dif.flush) begin
      state_d = RUN;
    end else if (state_q == STALL) begin
      issue   = 1'b1;
      state_d = RUN;
    end else if (dif.instr_valid) begin
      if (hazard) begin
        hold_load = 1'b1;
        state_d   = STALL;
      end else begin
        issue = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      hold_instr_q <= '0;
      hold_npc_q   <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      ctrl_q       <= NOP_OPCODE;
      dest_q       <= '0;
      reg1_q       <= '0;
      reg2_q       <= '0;
      npc_q        <= '0;
      imm_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_ok) regs_q[dif.wb_index[3:0]] <= dif.wb_data;

      // A flush wipes the held instruction so it can never resurface.
      if (dif.flush) begin
        hold_instr_q <= '0;
        hold_npc_q   <= '0;
      end else if (hold_load) begin
        hold_instr_q <= dif.instr_in;
        hold_npc_q   <= dif.npc_in;
      end

      if (issue) begin
        ctrl_q  <= src_instr[15:11];
        dest_q  <= {1'b0, src_instr[10:7]};
        reg1_q  <= rd1;
        reg2_q  <= rd2;
        npc_q   <= src_npc;
        imm_q   <= src_instr[6:0];
        valid_q <= 1'b1;
      end else begin
        ctrl_q  <= NOP_OPCODE;
        dest_q  <= '0;
        reg1_q  <= '0;
        reg2_q  <= '0;
        npc_q   <= '0;
        imm_q   <= '0;
        valid_q <= 1'b0;
      end
    end
  end

  assign dif.control_in    = ctrl_q;
  assign dif.dest_index_in = dest_q;
  assign dif.reg1_data     = reg1_q;
  assign dif.reg2_data     = reg2_q;
  assign dif.npc           = npc_q;
  assign dif.immediate     = imm_q;
  assign dif.valid_out     = valid_q;
  assign dif.stall         = (state_q == STALL);

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios then randomized traffic against a behavioural model.
// Build with or without DECODE_BYPASS_EN; the model follows the same macro.
module tb_decode_stage;
  localparam logic [4:0] LOAD = 5'b10100;
  localparam logic [4:0] NOP  = 5'b00000;
`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_stage_if dif();

  decode_stage #(.LOAD_OPCODE(LOAD), .NOP_OPCODE(NOP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dif  (dif)
  );

  int checks = 0;
  int errors = 0;

  // Architectural view: register contents, whether an instruction is parked, and what Execute should see.
  logic [15:0] m_regs [16];
  bit          m_stalled;
  logic [15:0] m_hold, m_hold_pc;
  logic [4:0]  e_ctrl, e_dest;
  logic [15:0] e_r1, e_r2, e_npc;
  logic [6:0]  e_imm;
  logic        e_valid;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void set_bubble();
    e_ctrl = NOP; e_dest = 0; e_r1 = 0; e_r2 = 0; e_npc = 0; e_imm = 0; e_valid = 0;
  endfunction

  task automatic step(input logic rst, input logic [15:0] ins, input logic [15:0] pc,
                      input logic iv, input logic fl, input logic we,
                      input logic [4:0] widx, input logic [15:0] wd);
    bit          wr, hz;
    logic [15:0] src, src_pc;
    rst_n = rst; dif.instr_in = ins; dif.npc_in = pc; dif.instr_valid = iv;
    dif.flush = fl; dif.wb_en = we; dif.wb_index = widx; dif.wb_data = wd;

    wr = we && (widx < 5'd16) && (widx != 5'd0);
    hz = e_valid && (e_ctrl == LOAD) && (e_dest != 0) &&
         ({1'b0, ins[10:7]} == e_dest || {1'b0, ins[6:3]} == e_dest);
    src    = m_stalled ? m_hold : ins;
    src_pc = m_stalled ? m_hold_pc : pc;
    if (!rst) begin
      set_bubble();
      m_stalled = 0;
      foreach (m_regs[i]) m_regs[i] = 0;
    end else begin
      if (fl) begin
        set_bubble(); m_stalled = 0;
      end else if (m_stalled || (iv && !hz)) begin
        e_ctrl  = src[15:11];
        e_dest  = {1'b0, src[10:7]};
        e_r1    = (BYP && wr && widx[3:0] == src[10:7]) ? wd : m_regs[src[10:7]];
        e_r2    = (BYP && wr && widx[3:0] == src[6:3])  ? wd : m_regs[src[6:3]];
        e_npc   = src_pc;
        e_imm   = src[6:0];
        e_valid = 1;
        m_stalled = 0;
      end else if (iv) begin
        set_bubble(); m_stalled = 1; m_hold = ins; m_hold_pc = pc;
      end else begin
        set_bubble();
      end
      if (wr) m_regs[widx[3:0]] = wd;
    end

    @(posedge clk);
    #1;
    chk("control_in", {11'd0, dif.control_in}, {11'd0, e_ctrl});
    chk("dest_index_in", {11'd0, dif.dest_index_in}, {11'd0, e_dest});
    chk("reg1_data", dif.reg1_data, e_r1);
    chk("reg2_data", dif.reg2_data, e_r2);
    chk("npc", dif.npc, e_npc);
    chk("immediate", {9'd0, dif.immediate}, {9'd0, e_imm});
    chk("valid_out", {15'd0, dif.valid_out}, {15'd0, e_valid});
    chk("stall", {15'd0, dif.stall}, {15'd0, m_stalled});
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b);
    return {op, a, b, 3'b101};
  endfunction

  task automatic go(input logic [15:0] ins, input logic [15:0] pc);
    step(1, ins, pc, 1, 0, 0, 0, 0);
  endtask

  task automatic wb(input logic [4:0] idx, input logic [15:0] d);
    step(1, 0, 0, 0, 0, 1, idx, d);
  endtask

  initial begin
    m_stalled = 0; m_hold = 0; m_hold_pc = 0;
    foreach (m_regs[i]) m_regs[i] = 0;
    set_bubble();

    // Reset and basic operand read
    step(0, 16'hFFFF, 16'h1111, 1, 0, 1, 5'd3, 16'h7777);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_valid", {15'd0, dif.valid_out}, 16'd0);
    chk("reset_stall", {15'd0, dif.stall}, 16'd0);
    wb(5'd2, 16'd10);
    wb(5'd3, 16'd3);
    go(mk(5'b00001, 4'd2, 4'd3), 16'h0040);
    chk("basic_ctrl", {11'd0, dif.control_in}, 16'd1);
    chk("basic_dest", {11'd0, dif.dest_index_in}, 16'd2);
    chk("basic_reg1", dif.reg1_data, 16'd10);
    chk("basic_reg2", dif.reg2_data, 16'd3);

    // Load-use stall: fetch keeps presenting the dependent instruction
    go(mk(LOAD, 4'd4, 4'd1), 16'h0042);
    go(mk(5'b00010, 4'd5, 4'd4), 16'h0044);
    chk("lu_bubble_stall", {15'd0, dif.stall}, 16'd1);
    chk("lu_bubble_valid", {15'd0, dif.valid_out}, 16'd0);
    go(mk(5'b00010, 4'd5, 4'd4), 16'h0044);
    chk("lu_issue_npc", dif.npc, 16'h0044);
    chk("lu_issue_stall", {15'd0, dif.stall}, 16'd0);
    go(mk(5'b00011, 4'd2, 4'd2), 16'h0046);

    // Load-use on rs1 with a non-matching rs2, then flush while stalled
    go(mk(LOAD, 4'd6, 4'd0), 16'h0048);
    go(mk(5'b00100, 4'd6, 4'd9), 16'h004A);
    step(1, mk(5'b00101, 4'd1, 4'd1), 16'h004C, 1, 1, 0, 0, 0);
    chk("flush_valid", {15'd0, dif.valid_out}, 16'd0);
    chk("flush_stall", {15'd0, dif.stall}, 16'd0);
    go(mk(5'b00110, 4'd3, 4'd2), 16'h0060);
    chk("after_flush_npc", dif.npc, 16'h0060);

    // Same-edge writeback vs read
    wb(5'd5, 16'h0055);
    step(1, mk(5'b00001, 4'd5, 4'd5), 16'h0062, 1, 0, 1, 5'd5, 16'h1234);
    chk("same_edge_reg1", dif.reg1_data, BYP ? 16'h1234 : 16'h0055);
    go(mk(5'b00001, 4'd5, 4'd0), 16'h0064);
    chk("after_wb_reg1", dif.reg1_data, 16'h1234);

    // Ignored writes: R0 and out-of-range index
    wb(5'd0, 16'hFFFF);
    go(mk(5'b00001, 4'd0, 4'd0), 16'h0066);
    chk("r0_reads_zero", dif.reg1_data, 16'd0);
    wb(5'd20, 16'hBEEF);
    go(mk(5'b00001, 4'd4, 4'd3), 16'h0068);
    chk("idx20_ignored", dif.reg1_data, 16'd0);

    // Reset mid-stream, including while stalled
    go(mk(LOAD, 4'd2, 4'd0), 16'h0070);
    go(mk(5'b00001, 4'd2, 4'd3), 16'h0072);
    step(0, mk(5'b00001, 4'd2, 4'd3), 16'h0072, 1, 0, 0, 0, 0);
    chk("midrst_valid", {15'd0, dif.valid_out}, 16'd0);
    for (int i = 0; i < 8; i++) begin
      go(mk(5'b00111, 4'(2 * i), 4'(2 * i + 1)), 16'(16'h0100 + i));
      chk("post_rst_regs", dif.reg1_data | dif.reg2_data, 16'd0);
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [4:0]  op;
      logic        rst_r, fl_r, we_r, iv_r;
      op    = ($urandom_range(0, 2) == 0) ? LOAD : 5'($urandom);
      rst_r = ($urandom_range(0, 79) != 0);
      fl_r  = ($urandom_range(0, 11) == 0);
      we_r  = ($urandom_range(0, 1) == 0);
      iv_r  = ($urandom_range(0, 5) != 0);
      step(rst_r, mk(op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))) ^ 16'($urandom_range(0, 7)),
           16'($urandom), iv_r, fl_r, we_r, 5'($urandom_range(0, 20)), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
